// File: rtl/pingpangpong_arbiter_if.sv
// Agent handshake pulses and select/count outputs of the ping/pang/pong
// buffer ownership controller.
interface pingpangpong_arbiter_if;
  logic       sn_done;
  logic       cpu_acc;
  logic       cpu_rej;
  logic       fwd_done;
  logic [1:0] sn_sel;
  logic [1:0] cpu_sel;
  logic [1:0] fwd_sel;
  logic [1:0] ping_sel;
  logic [1:0] pang_sel;
  logic [1:0] pong_sel;
  logic [1:0] ready_cnt;
  logic [1:0] acc_cnt;

  modport master (
    output sn_done, cpu_acc, cpu_rej, fwd_done,
    input  sn_sel, cpu_sel, fwd_sel, ping_sel, pang_sel, pong_sel, ready_cnt, acc_cnt
  );

  modport slave (
    input  sn_done, cpu_acc, cpu_rej, fwd_done,
    output sn_sel, cpu_sel, fwd_sel, ping_sel, pang_sel, pong_sel, ready_cnt, acc_cnt
  );
endinterface

// File: rtl/pingpangpong_arbiter.sv
// Hands the three packet buffers to snooper, CPU and forwarder in arrival
// order; every select is registered.
module pingpangpong_arbiter #(
  parameter int unsigned FWD_ENABLE = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  pingpangpong_arbiter_if.slave  bus
);

  typedef enum logic [2:0] {B_EMPTY, B_SN, B_READY, B_CPU, B_ACC, B_FWD} buf_st_e;

  buf_st_e    st_q [3];
  buf_st_e    st_d [3];
  logic [1:0] bsel_q [3];
  logic [1:0] sn_sel_q, sn_sel_d, cpu_sel_q, cpu_sel_d, fwd_sel_q, fwd_sel_d;

  logic [1:0] rq_mem_q [3];
  logic [1:0] rq_wr_q, rq_wr_d, rq_rd_q, rq_rd_d, rq_cnt_q, rq_cnt_d;
  logic [1:0] aq_mem_q [3];
  logic [1:0] aq_wr_q, aq_wr_d, aq_rd_q, aq_rd_d, aq_cnt_q, aq_cnt_d;

  logic       rq_push, rq_pop, aq_push, aq_pop;
  logic [1:0] rq_push_idx, aq_push_idx;
  logic       sn_free;
  logic [1:0] sn_free_idx;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  function automatic logic [1:0] agent_of(input buf_st_e s);
    case (s)
      B_SN:    return 2'b01;
      B_CPU:   return 2'b10;
      B_FWD:   return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  // Lowest-index EMPTY buffer, from registered state only
  always_comb begin
    sn_free     = 1'b0;
    sn_free_idx = 2'd0;
    for (int i = 2; i >= 0; i--) begin
      if (st_q[i] == B_EMPTY) begin
        sn_free     = 1'b1;
        sn_free_idx = 2'(i);
      end
    end
  end

  // Each agent branch touches only a buffer in that agent's own state, so
  // the three branches never write the same st_d entry.
  always_comb begin
    for (int i = 0; i < 3; i++) st_d[i] = st_q[i];
    sn_sel_d    = sn_sel_q;
    cpu_sel_d   = cpu_sel_q;
    fwd_sel_d   = fwd_sel_q;
    rq_push     = 1'b0;
    rq_push_idx = 2'd0;
    rq_pop      = 1'b0;
    aq_push     = 1'b0;
    aq_push_idx = 2'd0;
    aq_pop      = 1'b0;

    if (sn_sel_q != 2'b00) begin
      if (bus.sn_done) begin
        st_d[sn_sel_q - 2'd1] = B_READY;
        rq_push               = 1'b1;
        rq_push_idx           = sn_sel_q - 2'd1;
        sn_sel_d              = 2'b00;
      end
    end else if (sn_free) begin
      st_d[sn_free_idx] = B_SN;
      sn_sel_d          = sn_free_idx + 2'd1;
    end

    if (cpu_sel_q != 2'b00) begin
      if (bus.cpu_acc && (FWD_ENABLE != 0)) begin
        st_d[cpu_sel_q - 2'd1] = B_ACC;
        aq_push                = 1'b1;
        aq_push_idx            = cpu_sel_q - 2'd1;
        cpu_sel_d              = 2'b00;
      end else if (bus.cpu_acc || bus.cpu_rej) begin
        st_d[cpu_sel_q - 2'd1] = B_EMPTY;
        cpu_sel_d              = 2'b00;
      end
    end else if (rq_cnt_q != 2'd0) begin
      rq_pop                   = 1'b1;
      st_d[rq_mem_q[rq_rd_q]]  = B_CPU;
      cpu_sel_d                = rq_mem_q[rq_rd_q] + 2'd1;
    end

    if (fwd_sel_q != 2'b00) begin
      if (bus.fwd_done) begin
        st_d[fwd_sel_q - 2'd1] = B_EMPTY;
        fwd_sel_d              = 2'b00;
      end
    end else if (aq_cnt_q != 2'd0) begin
      aq_pop                   = 1'b1;
      st_d[aq_mem_q[aq_rd_q]]  = B_FWD;
      fwd_sel_d                = aq_mem_q[aq_rd_q] + 2'd1;
    end

    rq_wr_d  = rq_push ? ptr_inc(rq_wr_q) : rq_wr_q;
    rq_rd_d  = rq_pop  ? ptr_inc(rq_rd_q) : rq_rd_q;
    rq_cnt_d = rq_cnt_q + 2'(rq_push) - 2'(rq_pop);
    aq_wr_d  = aq_push ? ptr_inc(aq_wr_q) : aq_wr_q;
    aq_rd_d  = aq_pop  ? ptr_inc(aq_rd_q) : aq_rd_q;
    aq_cnt_d = aq_cnt_q + 2'(aq_push) - 2'(aq_pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        st_q[i]   <= B_EMPTY;
        bsel_q[i] <= 2'b00;
      end
      sn_sel_q  <= 2'b00;
      cpu_sel_q <= 2'b00;
      fwd_sel_q <= 2'b00;
      rq_wr_q   <= 2'd0;
      rq_rd_q   <= 2'd0;
      rq_cnt_q  <= 2'd0;
      aq_wr_q   <= 2'd0;
      aq_rd_q   <= 2'd0;
      aq_cnt_q  <= 2'd0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        st_q[i]   <= st_d[i];
        bsel_q[i] <= agent_of(st_d[i]);
      end
      sn_sel_q  <= sn_sel_d;
      cpu_sel_q <= cpu_sel_d;
      fwd_sel_q <= fwd_sel_d;
      rq_wr_q   <= rq_wr_d;
      rq_rd_q   <= rq_rd_d;
      rq_cnt_q  <= rq_cnt_d;
      aq_wr_q   <= aq_wr_d;
      aq_rd_q   <= aq_rd_d;
      aq_cnt_q  <= aq_cnt_d;
    end
  end

  // Queue storage is never read while its count is zero, so it needs no reset
  always_ff @(posedge clk) begin
    if (rq_push) rq_mem_q[rq_wr_q] <= rq_push_idx;
    if (aq_push) aq_mem_q[aq_wr_q] <= aq_push_idx;
  end

  assign bus.sn_sel    = sn_sel_q;
  assign bus.cpu_sel   = cpu_sel_q;
  assign bus.fwd_sel   = fwd_sel_q;
  assign bus.ping_sel  = bsel_q[0];
  assign bus.pang_sel  = bsel_q[1];
  assign bus.pong_sel  = bsel_q[2];
  assign bus.ready_cnt = rq_cnt_q;
  assign bus.acc_cnt   = aq_cnt_q;

endmodule

// File: doc/pingpangpong_arbiter.md
Name: pingpangpong_arbiter

Overview:
- Ownership controller for the three packet buffers (ping, pang, pong). It generates every select consumed by the agent/buffer mux fabric: sn_sel, cpu_sel, fwd_sel, ping_sel, pang_sel and pong_sel.
- It tracks each buffer's life cycle: filled by the snooper, then filtered by the CPU, then drained by the forwarder.
- It hands buffers to each agent in packet-arrival order, using two 3-deep index queues.

Parameters:
- FWD_ENABLE, default 1. If 0, there is no forwarder: cpu_acc frees the buffer exactly as cpu_rej does, acc_q stays empty and fwd_sel stays 00.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- sn_done  in  1  1-cycle pulse: the snooper finished writing its granted buffer.
- cpu_acc  in  1  1-cycle pulse: the CPU accepts the packet in its granted buffer.
- cpu_rej  in  1  1-cycle pulse: the CPU rejects the packet in its granted buffer.
- fwd_done  in  1  1-cycle pulse: the forwarder finished reading its granted buffer.
- sn_sel  out  2  buffer owned by the snooper: 00 none, 01 ping, 10 pang, 11 pong.
- cpu_sel  out  2  buffer owned by the CPU; same encoding as sn_sel.
- fwd_sel  out  2  buffer owned by the forwarder; same encoding as sn_sel.
- ping_sel  out  2  agent owning ping: 00 none, 01 snooper, 10 CPU, 11 forwarder.
- pang_sel  out  2  agent owning pang; same encoding as ping_sel.
- pong_sel  out  2  agent owning pong; same encoding as ping_sel.
- ready_cnt  out  2  entries in ready_q (packets waiting for the CPU).
- acc_cnt  out  2  entries in acc_q (packets waiting for the forwarder).

Behaviour:
- Per-buffer state, index b in {0=ping, 1=pang, 2=pong}: EMPTY, SN, READY, CPU, ACC, FWD.
- Reset (async, rst=1):
  - all buffers EMPTY;
  - both queues empty;
  - all *_sel outputs 00;
  - ready_cnt and acc_cnt 0.
- All outputs are registered. Buffer selects are decoded from the next-state values:
  - SN -> 01, CPU -> 10, FWD -> 11, otherwise 00;
  - this keeps buffer selects cycle-consistent with the agent selects.
- Snooper grant:
  - condition: sn_sel==00 and at least one buffer EMPTY (registered state);
  - next edge, the lowest-index EMPTY buffer goes to SN and sn_sel = b+1.
- sn_done while sn_sel!=00:
  - buffer goes to READY and its index is pushed to ready_q;
  - sn_sel goes to 00;
  - the earliest regrant is one cycle later (one idle cycle is mandatory).
- CPU grant:
  - condition: cpu_sel==00 and ready_q not empty;
  - pop the head index, buffer goes to CPU, cpu_sel = b+1.
  - Grant latency: 1 cycle after the push becomes visible. An sn_done at cycle t gives cpu_sel valid at t+2.
- cpu_acc while cpu_sel!=00:
  - FWD_ENABLE=1: buffer goes to ACC and its index is pushed to acc_q;
  - FWD_ENABLE=0: buffer goes to EMPTY;
  - in both cases cpu_sel goes to 00.
- cpu_rej while cpu_sel!=00: buffer goes to EMPTY, cpu_sel goes to 00.
- cpu_acc and cpu_rej in the same cycle: cpu_acc wins.
- Forwarder grant:
  - condition: fwd_sel==00 and acc_q not empty;
  - pop the head index, buffer goes to FWD, fwd_sel = b+1.
- fwd_done while fwd_sel!=00: buffer goes to EMPTY, fwd_sel goes to 00.
- A done/acc/rej pulse arriving while the matching *_sel==00 is ignored and causes no state change.
- A buffer freed at cycle t is EMPTY from t+1. The snooper can therefore hold it from t+2.
- Queues:
  - 3-entry circular FIFOs with 2-bit pointers wrapping 2->0;
  - they cannot overflow, because only three buffers exist;
  - a push and a pop in the same cycle are both honoured, and the count is unchanged.
- Invariants:
  - each buffer has exactly one state;
  - no two agent selects are equal and non-zero;
  - ready_cnt + acc_cnt + (number of SN/CPU/FWD/EMPTY buffers) = 3.
- Reset mid-operation: every grant is withdrawn at once and all state returns to the reset values.

Test Plan:
- Single packet path:
  - release reset: sn_sel=01 at cycle 1;
  - sn_done at cycle 5: ping READY, and cpu_sel=01 with ping_sel=10 at cycle 7;
  - cpu_acc: fwd_sel=01, ping_sel=11 two cycles later;
  - fwd_done: ping_sel=00 and sn_sel re-grants ping.
- Fill all buffers, CPU stalled:
  - three sn_done pulses give grants ping, pang, pong in that order;
  - 4th grant withheld: sn_sel stays 00;
  - ready_cnt=2 once the CPU holds ping.
- Out-of-order free:
  - CPU rejects pang while ping is in FWD;
  - the next snooper grant is pang (10), not pong;
  - CPU service order still follows ready_q order.
- Simultaneous events:
  - cpu_acc and cpu_rej together -> buffer goes to ACC;
  - sn_done and a CPU pop in the same cycle -> ready_cnt unchanged.
- FWD_ENABLE=0: cpu_acc frees the buffer, fwd_sel stays 00 and acc_cnt stays 0.
- Async reset while all three buffers are owned: all selects 00 immediately, with no clk edge required.
